// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit_pkg : shared fetch-stage state encodings and defaults    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] c_NOP              = 32'h0000_0000;
  localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          c_DEFAULT_PC_STEP  = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_skid_buf : one-entry {valid, pc, instr} holding register      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_skid_buf #(
  parameter int AW = 32,
  parameter int IW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] load_pc,
  input  logic [IW-1:0] load_instr,
  output logic          valid,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] instr
);

  logic          r_valid;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_instr;

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_pc    <= load_pc;
      r_instr <= load_instr;
    end
  end

  assign valid = r_valid;
  assign pc    = r_pc;
  assign instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : PC owner, req/ack instruction fetch, IF/ID presenter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          IW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(c_DEFAULT_RESET_PC),
  parameter int          PC_STEP  = c_DEFAULT_PC_STEP
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Stall,
  input  logic          Redirect,
  input  logic [AW-1:0] RedirectPC,
  output logic          ImemReq,
  output logic [AW-1:0] ImemAddr,
  input  logic          ImemAck,
  input  logic [IW-1:0] ImemData,
  output logic [AW-1:0] IfPC,
  output logic [IW-1:0] IfInstr,
  output logic          IfValid
);

  fetch_state_t  r_state;
  logic [AW-1:0] r_pc;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_if_pc;
  logic [IW-1:0] r_if_instr;
  logic          r_if_valid;

  logic [AW-1:0] w_pc_next;
  logic          w_skid_load;
  logic          w_skid_clear;
  logic          w_skid_valid;
  logic [AW-1:0] w_skid_pc;
  logic [IW-1:0] w_skid_instr;

  assign w_pc_next    = r_pc + AW'(PC_STEP);
  assign w_skid_load  = (r_state == S_REQ) && ImemAck && !Redirect && Stall;
  assign w_skid_clear = Redirect || ((r_state == S_HOLD) && !Stall);

  fetch_skid_buf #(
    .AW(AW),
    .IW(IW)
  ) u_skid (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (w_skid_load),
    .clear      (w_skid_clear),
    .load_pc    (r_pc),
    .load_instr (ImemData),
    .valid      (w_skid_valid),
    .pc         (w_skid_pc),
    .instr      (w_skid_instr)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_if_pc    <= '0;
      r_if_instr <= IW'(c_NOP);
      r_if_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          if (Redirect) begin
            r_pc       <= RedirectPC;
            r_addr     <= RedirectPC;
            r_if_valid <= 1'b0;
          end else begin
            r_addr <= r_pc;
          end
        end

        S_REQ: begin
          if (Redirect) begin
            r_pc       <= RedirectPC;
            r_if_valid <= 1'b0;
            if (ImemAck) begin
              r_addr <= RedirectPC;
            end else begin
              // Old read is still outstanding; keep its address until the ack.
              r_state <= S_DROP;
            end
          end else if (ImemAck) begin
            r_pc   <= w_pc_next;
            r_addr <= w_pc_next;
            if (Stall) begin
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end else begin
              r_if_pc    <= r_pc;
              r_if_instr <= ImemData;
              r_if_valid <= 1'b1;
            end
          end else if (!Stall) begin
            r_if_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (Redirect) begin
            r_pc       <= RedirectPC;
            r_addr     <= RedirectPC;
            r_if_valid <= 1'b0;
            r_state    <= S_REQ;
            r_req      <= 1'b1;
          end else if (!Stall) begin
            r_if_pc    <= w_skid_pc;
            r_if_instr <= w_skid_instr;
            r_if_valid <= w_skid_valid;
            r_addr     <= r_pc;
            r_state    <= S_REQ;
            r_req      <= 1'b1;
          end
        end

        S_DROP: begin
          if (Redirect) begin
            r_pc       <= RedirectPC;
            r_if_valid <= 1'b0;
          end
          if (ImemAck) begin
            r_state <= S_REQ;
            r_addr  <= Redirect ? RedirectPC : r_pc;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign ImemReq  = r_req;
  assign ImemAddr = r_addr;
  assign IfPC     = r_if_pc;
  assign IfInstr  = r_if_instr;
  assign IfValid  = r_if_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit : directed vector bench for fetch_unit                |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] IfPC;
  logic [31:0] IfInstr;
  logic        IfValid;

  logic ack_tied;
  logic man_ack;
  int   n_vec;
  int   n_err;

  // Memory model: data is the inverted address; ack either tracks req or is manual.
  assign ImemData = ~ImemAddr;
  assign ImemAck  = ack_tied ? ImemReq : man_ack;

  fetch_unit u_dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (ImemAck),
    .ImemData   (ImemData),
    .IfPC       (IfPC),
    .IfInstr    (IfInstr),
    .IfValid    (IfValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [18];

  // ImemAddr is only compared while a request is outstanding.
  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
    logic bad;
    n_vec++;
    bad = (ImemReq !== e_req) || (e_req && (ImemAddr !== e_addr)) ||
          (IfValid !== e_valid) || (IfPC !== e_pc) || (IfInstr !== e_instr);
    if (bad) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h, expected req=%b addr=%h valid=%b pc=%h instr=%h",
               name, ImemReq, ImemAddr, IfValid, IfPC, IfInstr, e_req, e_addr, e_valid, e_pc, e_instr);
    end
  endtask

  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc);
    Stall      = stall;
    Redirect   = redir;
    RedirectPC = rpc;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Rst = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    ack_tied = 1'b1; man_ack = 1'b0;

    //          rst  stl  rdr  rpc           req  addr          vld  pc            instr
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0,        32'hFFFFFFFF};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h4,        32'hFFFFFFFB};
    tbl[4]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'h8,        32'hFFFFFFF7};
    tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
    tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    tbl[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0,        32'hFFFFFFFF};
    tbl[8]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'h4,        32'hFFFFFFFB};
    tbl[9]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h4,        32'hFFFFFFFB};
    tbl[10] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h4,        32'hFFFFFFFB};
    tbl[11] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h4,        32'hFFFFFFFB};
    tbl[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b1,32'h8,        32'hFFFFFFF7};
    tbl[13] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b1,32'hC,        32'hFFFFFFF3};
    tbl[14] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h14,       1'b1,32'h10,       32'hFFFFFFEF};
    tbl[15] = '{1'b1,1'b0,1'b1,32'hFFFFFFFC, 1'b1,32'hFFFFFFFC, 1'b0,32'h10,       32'hFFFFFFEF};
    tbl[16] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'hFFFFFFFC, 32'h00000003};
    tbl[17] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0,        32'hFFFFFFFF};

    @(negedge Clk);
    for (int i = 0; i < 18; i++) begin
      Rst = tbl[i].rst_n;
      step(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
            tbl[i].e_pc, tbl[i].e_instr);
    end

    // Redirect while a slow read is outstanding: old address held, data dropped.
    ack_tied = 1'b0; man_ack = 1'b0;
    step(1'b0, 1'b1, 32'h100);
    check("t3_redirect_wait", 1'b1, 32'h4, 1'b0, 32'h0, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 32'h0);
    check("t3_still_wait", 1'b1, 32'h4, 1'b0, 32'h0, 32'hFFFFFFFF);
    man_ack = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    check("t3_ack_dropped", 1'b1, 32'h100, 1'b0, 32'h0, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 32'h0);
    check("t3_new_stream", 1'b1, 32'h104, 1'b1, 32'h100, 32'hFFFFFEFF);

    // Redirect, ack and Stall in the same cycle.
    step(1'b1, 1'b1, 32'h200);
    check("t4_all_at_once", 1'b1, 32'h200, 1'b0, 32'h100, 32'hFFFFFEFF);
    step(1'b0, 1'b0, 32'h0);
    check("t4_fetch_target", 1'b1, 32'h204, 1'b1, 32'h200, 32'hFFFFFDFF);

    // Asynchronous reset asserted between clock edges.
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1 check("t6_async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge Clk);
    ack_tied = 1'b1;
    Rst = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    check("t6_release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("t6_first_instr", 1'b1, 32'h4, 1'b1, 32'h0, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
